serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one instance of the existing 1-bit full adder, `full_add`.
- Loads two operands and a carry-in on a start pulse.
- Adds one bit per clock, LSB first, and feeds each carry-out back through a carry flip-flop.
- Presents the registered WIDTH-bit sum and final carry with a one-cycle done pulse.
- Sits directly upstream of `full_add`, supplying its a/b/cin each cycle and consuming its sum/cout.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range WIDTH >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- start  input  1  request to begin an addition; sampled on rising clk.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while bits are being added (RUN state).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered final carry; held until the next completion.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, any state) forces:
  - state IDLE, busy 0, done 0, sum 0, cout 0;
  - shift registers 0, carry flip-flop 0, bit counter 0.
- An operation in progress is aborted with no result. Operation resumes on the first clk edge after rst deasserts.
- IDLE:
  - start=1 at an edge loads a into shA, b into shB, cin into the carry flip-flop.
  - Clears the bit counter and moves to RUN. start=0 stays in IDLE.
- RUN, each edge:
  - `full_add` inputs are shA[0], shB[0] and the carry flip-flop.
  - The full-adder sum bit shifts into the MSB of the partial-sum register (right shift).
  - Carry flip-flop takes the full-adder cout. shA and shB shift right by 1. Counter increments.
- RUN, on the edge where the counter equals WIDTH-1 (the WIDTH-th bit):
  - The partial sum, including this edge's bit, is copied to sum.
  - The full-adder cout is copied to cout.
  - State moves to DONE.
- DONE: done=1 for this single cycle.
  - start=1 at the next edge is accepted exactly as in IDLE (back-to-back), giving RUN.
  - Otherwise the state moves to IDLE.
- Latency:
  - start is sampled at edge E0.
  - The result and done appear after edge E_WIDTH, i.e. the done cycle begins WIDTH edges after E0.
  - Throughput is one addition per WIDTH+1 cycles.
- busy=1 exactly in RUN; done=1 exactly in DONE. Both are decoded from registered state (no combinational path from inputs).
- start during RUN is ignored. Operands and cin are captured only at acceptance, so input changes after that have no effect.
- sum/cout change only on the completion edge or on reset, and are stable in between.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width is $clog2(WIDTH)+1. No wrap-around inside one operation.
- WIDTH=1: a single RUN cycle.

Decomposition:
- Shared include file holds the state-encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) for reuse by the bench.
- One sub-module: the existing `full_add` (ports a, b, cin, sum, cout), instantiated once.
- The carry flip-flop, shift registers, counter and FSM live in serial_adder.

Test Plan:
All cases use WIDTH=8.
- a=0x5A, b=0x3C, cin=0, start one cycle → busy high 8 cycles, then done one cycle, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. sum/cout stay 0xFF/1 for 20 idle cycles after done.
- Start a=0x10, b=0x20; pulse start with a=0x77 on the 3rd RUN cycle → ignored, result sum=0x30, done only once.
- Start a=0xAA, b=0x55; assert rst asynchronously mid-cycle during RUN → busy, done, sum, cout go 0 immediately. No done pulse after release.
- Hold start=1 continuously with a=0x01, b=0x02 → done pulses every 9 cycles, sum=0x03 each time, back-to-back accept from DONE.
- Every case: no X/Z on sum, cout, busy or done after reset release. Any mismatch is recorded with the first-error time and reported PASS/FAIL.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder.
// State encoding is exported so benches can decode state values.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Counter holds 0..WIDTH-1 with headroom, so it never wraps in one op.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_add.sv
// Single-bit full adder, the arithmetic core of the serial adder.
// Purely combinational.
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder, LSB first,
// carry recirculated through a flop, done pulse on completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] psum_nx;
  logic             last_bit;

  full_add u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New bit enters at the MSB; after WIDTH shifts it is aligned.
  generate
    if (WIDTH == 1) begin : g_psum1
      assign psum_nx = fa_sum;
    end else begin : g_psumn
      assign psum_nx = {fa_sum, psum_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          carry_d = cin;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        psum_d  = psum_nx;
        carry_d = fa_cout;
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = psum_nx;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed
// operations plus a cycle-level reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int  n_tests = 0;
  int  n_fail = 0;
  time first_err = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (first_err == 0) first_err = $time;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request yields a+b+cin after
  // 8 busy cycles; start only counts when not busy.
  int       m_left = 0;
  bit       m_done = 0;
  bit [8:0] m_res = '0;
  bit [7:0] m_sum = '0;
  bit       m_cout = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 0;
      m_sum  = '0;
      m_cout = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        {m_cout, m_sum} = m_res;
      end
    end else if (start) begin
      m_res  = 9'(a) + 9'(b) + 9'(cin);
      m_left = 8;
      m_done = 0;
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("xz", 32'($isunknown({busy, done, sum, cout})), 0);
      chk("m_busy", 32'(busy), 32'(m_left > 0));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_sum", 32'(sum), 32'(m_sum));
      chk("m_cout", 32'(cout), 32'(m_cout));
    end
  end

  task automatic do_op(input string nm, input logic [7:0] ia,
                       input logic [7:0] ib, input logic ic,
                       input logic [7:0] es, input logic ec);
    int  bc;
    bit  got;
    bc  = 0;
    got = 0;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;
    for (int n = 0; n < 30 && !got; n++) begin
      if (done) got = 1;
      else begin
        if (busy) bc++;
        @(negedge clk);
      end
    end
    chk({nm, "_got_done"}, 32'(got), 1);
    chk({nm, "_busy_cycles"}, bc, 8);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int nd;
    int last_i;
    logic [7:0] s_at;
    #1 rst = 1'b1;
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    do_op("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    do_op("ffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    chk("hold_sum", 32'(sum), 32'h FF);
    chk("hold_cout", 32'(cout), 1);

    // start pulse during RUN must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    s_at = '0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        nd++;
        s_at = sum;
      end
      @(negedge clk);
    end
    chk("ign_done_count", nd, 1);
    chk("ign_sum", 32'(s_at), 32'h30);

    // continuous start: back-to-back from DONE
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    nd = 0;
    last_i = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_sum", 32'(sum), 32'h03);
        if (last_i >= 0) chk("b2b_period", i - last_i, 9);
        else chk("b2b_first", i, 8);
        last_i = i;
        nd++;
      end
    end
    chk("b2b_count", nd, 4);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // asynchronous abort mid-RUN
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);

    if (n_fail != 0)
      $display("first error at %0t", first_err);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
